packing_fifo: RTL and testbench
===============================

Name: packing_fifo

Overview:
Narrow-in / wide-out packing FIFO that generalises the team's fixed-ratio byte-to-frame FIFO. Single WIDTH-bit words are written with valid/ready. Each read pops a variable number of words, rd_len (1..MAX_READ), chosen per transaction, into a registered MAX_READ-lane output stage with its own valid/ready handshake. Sits between the sampler byte stream and the sweeper/PLL frame consumers. Adds flush, a sticky overflow flag and non-power-of-two depth support.

Parameters:
WIDTH, 8, bits per word
DEPTH, 16, storage entries; any integer >= MAX_READ, need not be a power of two
MAX_READ, 11, output lanes (maximum words per pop), >= 1
ALMOST_FULL_THRESH, DEPTH-2, almost_full asserted when count >= this value
ALMOST_EMPTY_THRESH, 2, almost_empty asserted when count <= this value

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
flush  input  1  synchronous clear of storage and output stage
s_valid  input  1  write word present
s_data  input  WIDTH  write word
s_ready  output  1  FIFO can accept a word
rd_len  input  $clog2(MAX_READ+1)  words requested for the next pop
m_valid  output  1  output stage holds a frame
m_ready  input  1  consumer accepts the frame
m_data  output  WIDTH*MAX_READ  lane i = bits [i*WIDTH +: WIDTH]; lane 0 = oldest word
m_len  output  $clog2(MAX_READ+1)  valid lanes in m_data
count  output  $clog2(DEPTH+1)  words in storage (excludes the output stage)
almost_full  output  1  count >= ALMOST_FULL_THRESH
almost_empty  output  1  count <= ALMOST_EMPTY_THRESH
overflow  output  1  sticky: a write was attempted while s_ready was low

Behaviour:
- Reset (reset_n low at clk edge):
  - wr_ptr, rd_ptr, count, m_valid, m_data, m_len and overflow all go to 0.
  - s_ready is held low while reset_n is low.
- Priority: reset, then flush, then normal operation.
- flush:
  - Pointers, count and m_valid go to 0.
  - Any write or pop in the same cycle is discarded.
  - overflow is cleared.
- Write:
  - s_ready = (count != DEPTH), computed from the registered count; a same-cycle pop gives no credit.
  - A word is accepted when s_valid && s_ready: mem[wr_ptr] <= s_data.
  - wr_ptr wraps from DEPTH-1 to 0.
- Overflow: s_valid && !s_ready sets overflow. The word is dropped and state is unchanged.
- Effective length: eff_len = min(rd_len, MAX_READ).
- Load:
  - load = (!m_valid || m_ready) && eff_len != 0 && count >= eff_len.
  - The count used is the registered count; a word written in the same cycle is not eligible.
- On load:
  - Lanes i < eff_len take mem[(rd_ptr+i) mod DEPTH].
  - Lanes i >= eff_len are driven to 0.
  - m_len <= eff_len and m_valid <= 1.
  - rd_ptr <= (rd_ptr+eff_len) mod DEPTH. The modulo is computed at a width that holds DEPTH-1+MAX_READ without overflow.
- Frame consumed without a new load (m_valid && m_ready && !load): m_valid <= 0; m_data and m_len hold.
- Backpressure: while m_valid && !m_ready, m_data and m_len are stable and no load occurs.
- count update each cycle: count + (write accepted) - (load ? eff_len : 0). It never underflows, because load requires count >= eff_len.
- rd_len == 0 or rd_len > count: no load, m_valid is unaffected, and there is no error.
- Latency:
  - A word accepted at edge N is counted from cycle N+1.
  - With rd_len=1 and the output stage free, it appears on m_valid after edge N+1.
- Back-to-back frames: when m_valid && m_ready and enough data is present, the next frame loads on the same edge. Full throughput is one frame per cycle.
- Wrap-around: reads and writes spanning the DEPTH-1 to 0 boundary are seamless for non-power-of-two DEPTH.
- Flags almost_full and almost_empty are combinational from the registered count.
- Elaboration error if MAX_READ > DEPTH, MAX_READ < 1 or ALMOST_FULL_THRESH > DEPTH.

Test Plan:
- Defaults, rd_len=11, write bytes 0x00..0x0A, m_ready=1 -> exactly one frame: m_len=11, lane0=0x00, lane10=0x0A; count returns to 0.
- Write 16 words with m_ready=0 and rd_len=0 -> s_ready low and count=16, almost_full high; a 17th s_valid sets overflow; mem is unchanged and count stays 16.
- rd_len=5 with m_ready held low, then set high for 3 cycles after 16 words -> first frame held stable; then frames of 5, 5, 5 lanes on consecutive cycles; lanes 5..10 are 0; count ends at 1.
- Wrap-around: write 14, pop 11, write 10, pop 11 with rd_len=11 -> second frame lanes are words 11..21 in order, spanning index 15 to 0.
- Simultaneous write and load with count=11, rd_len=11 -> count becomes 1 next cycle; the new word is not in the frame.
- flush asserted with m_valid=1, count=7 and a write pending -> next cycle m_valid=0, count=0, overflow=0, the write is dropped; reset_n low mid-stream gives the same result, with s_ready low during reset.

Source files
------------

// File: rtl/packing_fifo_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | packing_fifo_if : write and frame-read handshake bundle for packing_fifo |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface packing_fifo_if #(
  parameter int WIDTH    = 8,
  parameter int MAX_READ = 11
);
  localparam int LW = $clog2(MAX_READ + 1);

  logic                      s_valid;
  logic [WIDTH-1:0]          s_data;
  logic                      s_ready;
  logic [LW-1:0]             rd_len;
  logic                      m_valid;
  logic                      m_ready;
  logic [WIDTH*MAX_READ-1:0] m_data;
  logic [LW-1:0]             m_len;

  modport slave (
    input  s_valid, s_data, rd_len, m_ready,
    output s_ready, m_valid, m_data, m_len
  );

  modport master (
    output s_valid, s_data, rd_len, m_ready,
    input  s_ready, m_valid, m_data, m_len
  );
endinterface
`default_nettype wire

// File: rtl/packing_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | packing_fifo : narrow-in / wide-out FIFO, variable words popped per frame |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module packing_fifo #(
  parameter int WIDTH               = 8,
  parameter int DEPTH               = 16,
  parameter int MAX_READ            = 11,
  parameter int ALMOST_FULL_THRESH  = DEPTH - 2,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input  wire logic                       clk,
  input  wire logic                       reset_n,
  input  wire logic                       flush,
  packing_fifo_if.slave                   bus,
  output logic [$clog2(DEPTH+1)-1:0]      count,
  output logic                            almost_full,
  output logic                            almost_empty,
  output logic                            overflow
);
  localparam int LW = $clog2(MAX_READ + 1);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = $clog2(DEPTH + MAX_READ);
  localparam int AE = (ALMOST_EMPTY_THRESH >= DEPTH) ? DEPTH : ALMOST_EMPTY_THRESH;
  localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [LW-1:0] MAX_L   = LW'(MAX_READ);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

  if (MAX_READ > DEPTH || MAX_READ < 1 || ALMOST_FULL_THRESH > DEPTH) begin : g_param_error
    $error("packing_fifo: illegal MAX_READ / DEPTH / ALMOST_FULL_THRESH combination");
  end

  logic [WIDTH-1:0]          mem_q [DEPTH];
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             count_q, count_d;
  logic                      m_valid_q, m_valid_d;
  logic [WIDTH*MAX_READ-1:0] m_data_q, m_data_d;
  logic [LW-1:0]             m_len_q, m_len_d;
  logic                      overflow_q, overflow_d;

  logic                      s_ready;
  logic                      wr_en;
  logic                      load;
  logic [LW-1:0]             eff_len;
  logic [WIDTH*MAX_READ-1:0] frame;

  // Operands are always below 2*DEPTH, so one conditional subtract is a full modulo.
  function automatic logic [SW-1:0] wrap(input logic [SW-1:0] v);
    return (v >= DEPTH_S) ? v - DEPTH_S : v;
  endfunction

  always_comb begin
    eff_len = (bus.rd_len > MAX_L) ? MAX_L : bus.rd_len;
    s_ready = reset_n && (count_q != DEPTH_C);
    wr_en   = bus.s_valid && s_ready && !flush;
    load    = !flush && (!m_valid_q || bus.m_ready) && (eff_len != '0)
              && (count_q >= CW'(eff_len));
  end

  for (genvar i = 0; i < MAX_READ; i++) begin : g_lane
    logic [SW-1:0] idx;
    assign idx = wrap(SW'(rd_ptr_q) + SW'(i));
    assign frame[i*WIDTH +: WIDTH] = (LW'(i) < eff_len) ? mem_q[PW'(idx)] : '0;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_len_d    = m_len_q;
    overflow_d = overflow_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      m_valid_d  = 1'b0;
      overflow_d = 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = (wr_ptr_q == LAST_P) ? '0 : wr_ptr_q + PW'(1);
      end
      if (bus.s_valid && !s_ready) begin
        overflow_d = 1'b1;
      end
      if (load) begin
        rd_ptr_d  = PW'(wrap(SW'(rd_ptr_q) + SW'(eff_len)));
        m_valid_d = 1'b1;
        m_data_d  = frame;
        m_len_d   = eff_len;
      end else if (m_valid_q && bus.m_ready) begin
        m_valid_d = 1'b0;
      end
      count_d = count_q + CW'(wr_en) - (load ? CW'(eff_len) : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_len_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_len_q    <= m_len_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= bus.s_data;
    end
  end

  assign bus.s_ready   = s_ready;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_data_q;
  assign bus.m_len     = m_len_q;
  assign count         = count_q;
  assign almost_full   = (count_q >= AF_C);
  assign almost_empty  = (count_q <= AE_C);
  assign overflow      = overflow_q;
endmodule
`default_nettype wire

// File: tb/tb_packing_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_packing_fifo : queue-model bench for packing_fifo, directed + random  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_packing_fifo;
  localparam int WIDTH    = 8;
  localparam int DEPTH    = 16;
  localparam int MAX_READ = 11;
  localparam int LW       = 4;
  localparam int CW       = 5;
  localparam int AFT      = DEPTH - 2;
  localparam int AET      = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush;
  logic [CW-1:0] count;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;

  always #5 clk = ~clk;

  packing_fifo_if #(.WIDTH(WIDTH), .MAX_READ(MAX_READ)) bus ();

  packing_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_READ(MAX_READ),
    .ALMOST_FULL_THRESH(AFT), .ALMOST_EMPTY_THRESH(AET)
  ) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow)
  );

  // Reference: storage is a plain queue, the output stage is a lane array.
  logic [WIDTH-1:0] q [$];
  logic             mv;
  logic [WIDTH-1:0] mlane [MAX_READ];
  logic [LW-1:0]    mlen;
  logic             ovf;
  int               total = 0;
  int               bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH*MAX_READ-1:0] exp_mdata();
    logic [WIDTH*MAX_READ-1:0] v;
    for (int i = 0; i < MAX_READ; i++) v[i*WIDTH +: WIDTH] = mlane[i];
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] lane(input int k);
    return bus.m_data[k*WIDTH +: WIDTH];
  endfunction

  task automatic model_step();
    int n;
    int el;
    bit sr;
    bit ld;
    if (!reset_n) begin
      q.delete();
      mv = 1'b0; mlen = '0; ovf = 1'b0;
      for (int i = 0; i < MAX_READ; i++) mlane[i] = '0;
    end else if (flush) begin
      q.delete();
      mv = 1'b0; ovf = 1'b0;
    end else begin
      n  = q.size();
      sr = (n != DEPTH);
      el = (int'(bus.rd_len) > MAX_READ) ? MAX_READ : int'(bus.rd_len);
      ld = (!mv || bus.m_ready) && el != 0 && n >= el;
      if (ld) begin
        for (int i = 0; i < MAX_READ; i++) begin
          if (i < el) mlane[i] = q.pop_front();
          else        mlane[i] = '0;
        end
        mv = 1'b1;
        mlen = LW'(el);
      end else if (mv && bus.m_ready) begin
        mv = 1'b0;
      end
      if (bus.s_valid) begin
        if (sr) q.push_back(bus.s_data);
        else    ovf = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    check("s_ready",      bus.s_ready,  reset_n && (q.size() != DEPTH));
    check("count",        count,        q.size());
    check("almost_full",  almost_full,  q.size() >= AFT);
    check("almost_empty", almost_empty, q.size() <= AET);
    check("overflow",     overflow,     ovf);
    check("m_valid",      bus.m_valid,  mv);
    check("m_len",        bus.m_len,    mlen);
    check("m_data",       bus.m_data,   exp_mdata());
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic sv, input logic [WIDTH-1:0] sd, input logic [LW-1:0] rl,
                       input logic mr, input logic fl);
    bus.s_valid = sv; bus.s_data = sd; bus.rd_len = rl; bus.m_ready = mr; flush = fl;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(0, 8'h00, 4'd0, 0, 0);
    cycle(); cycle();
    check("rst_s_ready", bus.s_ready, 1'b0);
    check("rst_count",   count,       5'd0);
    check("rst_m_valid", bus.m_valid, 1'b0);
    reset_n = 1'b1;

    // One full 11-word frame
    for (int i = 0; i < 11; i++) begin drive(1, 8'(i), 4'd11, 1, 0); cycle(); end
    drive(0, 8'h00, 4'd11, 1, 0); cycle();
    check("t1_m_valid", bus.m_valid, 1'b1);
    check("t1_m_len",   bus.m_len,   4'd11);
    check("t1_lane0",   lane(0),     8'h00);
    check("t1_lane10",  lane(10),    8'h0A);
    check("t1_count",   count,       5'd0);

    // Fill to full, then overflow attempt
    drive(0, 8'h00, 4'd0, 1, 0); cycle();
    check("t2_m_valid", bus.m_valid, 1'b0);
    for (int i = 0; i < 16; i++) begin drive(1, 8'(8'h20 + i), 4'd0, 0, 0); cycle(); end
    check("t2_count",   count,       5'd16);
    check("t2_s_ready", bus.s_ready, 1'b0);
    check("t2_afull",   almost_full, 1'b1);
    drive(1, 8'hFF, 4'd0, 0, 0); cycle();
    check("t2_overflow", overflow, 1'b1);
    check("t2_count2",   count,    5'd16);

    // Five-word frames under backpressure, then released
    drive(0, 8'h00, 4'd5, 0, 0); cycle();
    check("t3_lane0a", lane(0), 8'h20);
    check("t3_lane4a", lane(4), 8'h24);
    check("t3_count",  count,   5'd11);
    cycle();
    check("t3_hold_lane0", lane(0),   8'h20);
    check("t3_hold_len",   bus.m_len, 4'd5);
    drive(0, 8'h00, 4'd5, 1, 0); cycle();
    check("t3_lane0b", lane(0), 8'h25);
    check("t3_upper0", bus.m_data[87:40], 48'h0);
    cycle();
    check("t3_lane0c", lane(0), 8'h2A);
    check("t3_count1", count,   5'd1);
    cycle();
    check("t3_drained", bus.m_valid, 1'b0);
    drive(0, 8'h00, 4'd1, 1, 0); cycle();
    check("t3_last_word", lane(0),   8'h2F);
    check("t3_last_len",  bus.m_len, 4'd1);

    // Wrap across the DEPTH-1 -> 0 boundary
    drive(0, 8'h00, 4'd0, 1, 1); cycle();
    check("t4_flush_ovf", overflow,    1'b0);
    check("t4_flush_mv",  bus.m_valid, 1'b0);
    for (int k = 0; k < 14; k++) begin drive(1, 8'(k), 4'd0, 1, 0); cycle(); end
    drive(0, 8'h00, 4'd11, 1, 0); cycle();
    check("t4_count3", count, 5'd3);
    for (int k = 14; k < 24; k++) begin drive(1, 8'(k), 4'd0, 1, 0); cycle(); end
    drive(0, 8'h00, 4'd11, 1, 0); cycle();
    check("t4_lane0",  lane(0),  8'd11);
    check("t4_lane4",  lane(4),  8'd15);
    check("t4_lane5",  lane(5),  8'd16);
    check("t4_lane10", lane(10), 8'd21);
    check("t4_count",  count,    5'd2);

    // Same-cycle write and load
    for (int k = 0; k < 9; k++) begin drive(1, 8'(8'h40 + k), 4'd0, 1, 0); cycle(); end
    drive(1, 8'h77, 4'd11, 1, 0); cycle();
    check("t5_count",  count,    5'd1);
    check("t5_lane0",  lane(0),  8'd22);
    check("t5_lane10", lane(10), 8'h48);

    // Flush with a held frame and a pending write
    for (int k = 0; k < 6; k++) begin drive(1, 8'(8'h50 + k), 4'd0, 0, 0); cycle(); end
    check("t6_pre_mv",    bus.m_valid, 1'b1);
    check("t6_pre_count", count,       5'd7);
    drive(1, 8'h99, 4'd0, 0, 1); cycle();
    check("t6_mv",    bus.m_valid, 1'b0);
    check("t6_count", count,       5'd0);
    check("t6_ovf",   overflow,    1'b0);

    // Reset mid-stream
    for (int k = 0; k < 5; k++) begin drive(1, 8'(k), 4'd3, 1, 0); cycle(); end
    reset_n = 1'b0;
    drive(1, 8'hAA, 4'd3, 1, 0); cycle();
    check("t7_s_ready", bus.s_ready, 1'b0);
    check("t7_mv",      bus.m_valid, 1'b0);
    check("t7_count",   count,       5'd0);
    check("t7_m_data",  bus.m_data,  88'h0);
    cycle();
    reset_n = 1'b1;

    // Random traffic with phase-varying bias
    for (int c = 0; c < 4000; c++) begin
      int wr_bias;
      int rd_bias;
      wr_bias = ((c / 500) % 2 == 0) ? 90 : 40;
      rd_bias = ((c / 500) % 3 == 0) ? 30 : 80;
      reset_n = ($urandom_range(0, 399) != 0);
      drive(($urandom_range(0, 99) < wr_bias), 8'($urandom),
            ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 6)),
            ($urandom_range(0, 99) < rd_bias), ($urandom_range(0, 149) == 0));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
